// File: rtl/neuron_layer_act.sv
// neuron_layer_act: NUM_NEURONS-wide fixed-point dense layer with activation.
// A job is registered on acceptance, multiplied LANES inputs per cycle over BEATS
// cycles, then bias-added, rescaled, saturated and activated in one finishing cycle.
// Build option: define NEURON_LEAKY_RELU_EN to compile the leaky-ReLU mode (act_mode 2).
//
// Packing: a_in element i at [i*DATA_WIDTH +: DATA_WIDTH]; w_in weight [n][i] at
// [(n*INPUT_WIDTH+i)*DATA_WIDTH +: DATA_WIDTH]; bias/out_data neuron n at
// [n*DATA_WIDTH +: DATA_WIDTH]. All words are two's-complement signed.
module neuron_layer_act #(
  parameter int unsigned INPUT_WIDTH = 10,
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned LANES       = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH   = 48,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned LEAK_SHIFT  = 3
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [DATA_WIDTH*INPUT_WIDTH-1:0]           a_in,
  input  logic [DATA_WIDTH*NUM_NEURONS*INPUT_WIDTH-1:0] w_in,
  input  logic [DATA_WIDTH*NUM_NEURONS-1:0]           bias,
  input  logic [1:0]                                  act_mode,
  output logic [DATA_WIDTH*NUM_NEURONS-1:0]           out_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        busy
);

  localparam int unsigned Beats = (INPUT_WIDTH + LANES - 1) / LANES;
  // Operand stores are padded to a whole number of beats; pad slots hold zero.
  localparam int unsigned Pad   = Beats * LANES;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;

  localparam logic signed [ACC_WIDTH-1:0] SatMax =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SatMin =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StFin, StHold} state_e;

  state_e                        state_q;
  logic [BeatW-1:0]              beat_q;
  logic [1:0]                    mode_q;
  logic signed [DATA_WIDTH-1:0]  a_q    [Pad];
  logic signed [DATA_WIDTH-1:0]  w_q    [NUM_NEURONS][Pad];
  logic signed [DATA_WIDTH-1:0]  bias_q [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]   acc_q  [NUM_NEURONS];

  logic signed [DATA_WIDTH-1:0]  a_load    [Pad];
  logic signed [DATA_WIDTH-1:0]  a_next    [Pad];
  logic signed [DATA_WIDTH-1:0]  w_load    [NUM_NEURONS][Pad];
  logic signed [DATA_WIDTH-1:0]  w_next    [NUM_NEURONS][Pad];
  logic signed [DATA_WIDTH-1:0]  bias_load [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]   beat_sum  [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0]  fin_val   [NUM_NEURONS];

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    sum;
  logic signed [ACC_WIDTH-1:0]    y;
  logic signed [DATA_WIDTH-1:0]   sat;
  logic                           accept;

  assign in_ready = (state_q == StIdle) || ((state_q == StHold) && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != StIdle);

`ifndef NEURON_LEAKY_RELU_EN
  // Leak slope has no effect when the leaky mode is compiled out.
  logic unused_leak_shift;
  assign unused_leak_shift = ^LEAK_SHIFT;
`endif

  // Activation store: load view (zero-padded) and the next-beat view shifted down by LANES,
  // so the multipliers always read slots 0..LANES-1.
  for (genvar j = 0; j < Pad; j++) begin : g_act
    if (j < INPUT_WIDTH) begin : g_real
      assign a_load[j] = a_in[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_zero
      assign a_load[j] = '0;
    end
    if (j + LANES < Pad) begin : g_shift
      assign a_next[j] = a_q[j+LANES];
    end else begin : g_fill
      assign a_next[j] = '0;
    end
  end

  // Weight store per neuron, same load/shift arrangement as the activations.
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    assign bias_load[n] = bias[n*DATA_WIDTH +: DATA_WIDTH];
    for (genvar j = 0; j < Pad; j++) begin : g_w
      if (j < INPUT_WIDTH) begin : g_real
        assign w_load[n][j] = w_in[(n*INPUT_WIDTH+j)*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_zero
        assign w_load[n][j] = '0;
      end
      if (j + LANES < Pad) begin : g_shift
        assign w_next[n][j] = w_q[n][j+LANES];
      end else begin : g_fill
        assign w_next[n][j] = '0;
      end
    end
  end

  // Sum of the LANES sign-extended products for the current beat, per neuron.
  always_comb begin
    prod = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      beat_sum[n] = '0;
      for (int l = 0; l < LANES; l++) begin
        prod        = (2*DATA_WIDTH)'(a_q[l]) * (2*DATA_WIDTH)'(w_q[n][l]);
        beat_sum[n] = beat_sum[n] + ACC_WIDTH'(prod);
      end
    end
  end

  // Finishing datapath: bias add, rescale, saturate, then activation.
  always_comb begin
    sum = '0;
    y   = '0;
    sat = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      sum = acc_q[n] + (ACC_WIDTH'(bias_q[n]) <<< FRAC_BITS);
      y   = sum >>> FRAC_BITS;
      if (y > SatMax) begin
        sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (y < SatMin) begin
        sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        sat = y[DATA_WIDTH-1:0];
      end
      case (mode_q)
        2'd0: fin_val[n] = sat;
`ifdef NEURON_LEAKY_RELU_EN
        // Arithmetic shift rounds toward -inf.
        2'd2: fin_val[n] = sat[DATA_WIDTH-1] ? (sat >>> LEAK_SHIFT) : sat;
`else
        2'd2: fin_val[n] = sat[DATA_WIDTH-1] ? '0 : sat;
`endif
        default: fin_val[n] = sat[DATA_WIDTH-1] ? '0 : sat;
      endcase
    end
  end

  // Job control FSM, MAC accumulation and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      mode_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int j = 0; j < Pad; j++) begin
        a_q[j] <= '0;
      end
      for (int n = 0; n < NUM_NEURONS; n++) begin
        bias_q[n] <= '0;
        acc_q[n]  <= '0;
        for (int j = 0; j < Pad; j++) begin
          w_q[n][j] <= '0;
        end
      end
    end else begin
      case (state_q)
        StMac: begin
          for (int n = 0; n < NUM_NEURONS; n++) begin
            acc_q[n] <= acc_q[n] + beat_sum[n];
          end
          a_q <= a_next;
          w_q <= w_next;
          if (beat_q == BeatW'(Beats - 1)) begin
            beat_q  <= '0;
            state_q <= StFin;
          end else begin
            beat_q <= beat_q + BeatW'(1);
          end
        end
        StFin: begin
          for (int n = 0; n < NUM_NEURONS; n++) begin
            out_data[n*DATA_WIDTH +: DATA_WIDTH] <= fin_val[n];
          end
          out_valid <= 1'b1;
          state_q   <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
        end
      endcase
      // Acceptance overrides the HOLD exit so a new job starts with no bubble.
      if (accept) begin
        a_q     <= a_load;
        w_q     <= w_load;
        bias_q  <= bias_load;
        mode_q  <= act_mode;
        beat_q  <= '0;
        state_q <= StMac;
        for (int n = 0; n < NUM_NEURONS; n++) begin
          acc_q[n] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_layer_act.sv
// Bench for neuron_layer_act: default instance (LANES=4) plus a LANES=3 instance.
// Expected results are queued at acceptance and popped when out_valid appears.
`timescale 1ns/1ps
module tb_neuron_layer_act;

  localparam int IW = 10;
  localparam int NN = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_valid0, in_valid3, out_ready0, out_ready3;
  logic             in_ready0, in_ready3, out_valid0, out_valid3, busy0, busy3;
  logic [DW*IW-1:0]    a_in;
  logic [DW*NN*IW-1:0] w_in;
  logic [DW*NN-1:0]    bias;
  logic [1:0]          act_mode;
  logic [DW*NN-1:0]    out_data0, out_data3;

  logic signed [15:0] a_v [IW];
  logic signed [15:0] w_v [NN][IW];
  logic signed [15:0] b_v [NN];
  logic [63:0]        sb_q [$];

  int checks = 0;
  int errors = 0;

  neuron_layer_act dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a_in(a_in), .w_in(w_in), .bias(bias), .act_mode(act_mode),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0), .busy(busy0)
  );

  neuron_layer_act #(.LANES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .a_in(a_in), .w_in(w_in), .bias(bias), .act_mode(act_mode),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .busy(busy3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic rdy(input int sel);
    return (sel == 0) ? in_ready0 : in_ready3;
  endfunction

  function automatic logic ovld(input int sel);
    return (sel == 0) ? out_valid0 : out_valid3;
  endfunction

  function automatic logic [63:0] odat(input int sel);
    return (sel == 0) ? out_data0 : out_data3;
  endfunction

  // Reference neuron in wide integer arithmetic.
  function automatic logic [15:0] model(input int n, input logic [1:0] mode);
    longint s = 0;
    longint yv;
    for (int i = 0; i < IW; i++) s += longint'(a_v[i]) * longint'(w_v[n][i]);
    s += longint'(b_v[n]) * 256;
    yv = s >>> 8;
    if (yv > 32767) yv = 32767;
    else if (yv < -32768) yv = -32768;
    if (mode == 2'd0) begin
    end else if (mode == 2'd2) begin
`ifdef NEURON_LEAKY_RELU_EN
      if (yv < 0) yv = yv >>> 3;
`else
      if (yv < 0) yv = 0;
`endif
    end else begin
      if (yv < 0) yv = 0;
    end
    return 16'(yv);
  endfunction

  function automatic logic [63:0] model_vec(input logic [1:0] mode);
    return {model(3, mode), model(2, mode), model(1, mode), model(0, mode)};
  endfunction

  task automatic load_bus();
    for (int i = 0; i < IW; i++) a_in[i*DW +: DW] = a_v[i];
    for (int n = 0; n < NN; n++) begin
      bias[n*DW +: DW] = b_v[n];
      for (int i = 0; i < IW; i++) w_in[(n*IW+i)*DW +: DW] = w_v[n][i];
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < IW; i++) a_in[i*DW +: DW] = 16'($urandom);
    for (int i = 0; i < IW*NN; i++) w_in[i*DW +: DW] = 16'($urandom);
    for (int n = 0; n < NN; n++) bias[n*DW +: DW] = 16'($urandom);
    act_mode = 2'($urandom);
  endtask

  task automatic set_uniform(input int a, input int w, input int b);
    for (int i = 0; i < IW; i++) a_v[i] = 16'(a);
    for (int n = 0; n < NN; n++) begin
      b_v[n] = 16'(b);
      for (int i = 0; i < IW; i++) w_v[n][i] = 16'(w);
    end
  endtask

  // Offer a job until the DUT takes it; queue its expected result at the accepting edge.
  task automatic accept_job(input int sel, input logic [1:0] mode, input logic [63:0] exp,
                            output int waited);
    waited = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      load_bus();
      act_mode = mode;
      if (sel == 0) begin in_valid0 = 1'b1; out_ready0 = 1'b1; end
      else begin in_valid3 = 1'b1; out_ready3 = 1'b1; end
      #1;
      if (rdy(sel)) begin
        waited = k;
        break;
      end
    end
    if (waited < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout sel=%0d: in_ready never high within 20 cycles", sel);
      in_valid0 = 1'b0;
      in_valid3 = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back(exp);
    #1;
    in_valid0 = 1'b0;
    in_valid3 = 1'b0;
    scramble();
  endtask

  // Count edges from acceptance until out_valid is seen (-1 if never within 20).
  task automatic wait_valid(input int sel, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (ovld(sel)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pop_exp(output logic [63:0] e);
    if (sb_q.size() == 0) e = 'x;
    else e = sb_q.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid0 = 1'b0; in_valid3 = 1'b0; out_ready0 = 1'b1; out_ready3 = 1'b1;
    a_in = '0; w_in = '0; bias = '0; act_mode = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready0); end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    checks++;
    if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid0); end
    checks++;
    if (out_data0 !== 64'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data0); end
    checks++;
    if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_lanes3 got rdy=%b vld=%b busy=%b want 1 0 0", in_ready3, out_valid3, busy3);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_release got vld=%b busy=%b want 0 0", out_valid0, busy0);
    end
  endtask

  task automatic test_relu_basic();
    int w;
    int lat;
    logic [63:0] e;
    set_uniform(256, 128, 0);
    accept_job(0, 2'd1, {4{16'd1280}}, w);
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL relu_busy got %b want 1", busy0); end
    wait_valid(0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL relu_latency got %0d want 4", lat); end
    pop_exp(e);
    checks++;
    if (out_data0 !== e) begin errors++; $display("FAIL relu_data got %h want %h", out_data0, e); end
  endtask

  task automatic test_negative_modes();
    int w;
    int lat;
    logic [63:0] e;
    logic [15:0] v;
    int exp_tab [4];
    exp_tab[0] = -1280;
    exp_tab[1] = 0;
`ifdef NEURON_LEAKY_RELU_EN
    exp_tab[2] = -160;
`else
    exp_tab[2] = 0;
`endif
    exp_tab[3] = 0;
    set_uniform(256, -128, 0);
    for (int m = 0; m < 4; m++) begin
      v = 16'(exp_tab[m]);
      accept_job(0, 2'(m), {4{v}}, w);
      wait_valid(0, lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL neg_latency mode=%0d got %0d want 4", m, lat); end
      pop_exp(e);
      checks++;
      if (out_data0 !== e) begin
        errors++;
        $display("FAIL neg_data mode=%0d got %h want %h", m, out_data0, e);
      end
    end
  endtask

  task automatic test_saturation();
    int w;
    int lat;
    logic [63:0] e;
    logic [15:0] v;
    int ws [3];
    int ms [3];
    int es [3];
    ws[0] = 32767;  ms[0] = 0; es[0] = 32767;
    ws[1] = -32767; ms[1] = 0; es[1] = -32768;
    ws[2] = -32767; ms[2] = 1; es[2] = 0;
    for (int c = 0; c < 3; c++) begin
      set_uniform(32767, ws[c], 0);
      v = 16'(es[c]);
      accept_job(0, 2'(ms[c]), {4{v}}, w);
      wait_valid(0, lat);
      pop_exp(e);
      checks++;
      if (lat !== 4 || out_data0 !== e) begin
        errors++;
        $display("FAIL sat_case%0d got lat=%0d data=%h want lat=4 data=%h", c, lat, out_data0, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int lat;
    logic [63:0] e;
    logic [63:0] held;
    set_uniform(256, 128, 0);
    accept_job(0, 2'd1, {4{16'd1280}}, w);
    out_ready0 = 1'b0;
    wait_valid(0, lat);
    pop_exp(e);
    checks++;
    if (lat !== 4 || out_data0 !== e) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d data=%h want lat=4 data=%h", lat, out_data0, e);
    end
    held = out_data0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== held || in_ready0 !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cycle=%0d got vld=%b data=%h rdy=%b want 1 %h 0",
                 k, out_valid0, out_data0, in_ready0, held);
      end
    end
    set_uniform(256, -128, 0);
    accept_job(0, 2'd0, {4{16'hFB00}}, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL b2b_no_bubble got wait=%0d want 0", w); end
    checks++;
    if (out_valid0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handoff got vld=%b busy=%b want 0 1", out_valid0, busy0);
    end
    wait_valid(0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d want 4", lat); end
    pop_exp(e);
    checks++;
    if (out_data0 !== e) begin errors++; $display("FAIL b2b_second got %h want %h", out_data0, e); end
  endtask

  task automatic test_reset_midjob();
    int w;
    int lat;
    int seen;
    logic [63:0] e;
    set_uniform(256, 128, 0);
    accept_job(0, 2'd1, {4{16'd1280}}, w);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0 || out_data0 !== 64'd0) begin
      errors++;
      $display("FAIL midreset_state got vld=%b rdy=%b busy=%b data=%h want 0 1 0 0",
               out_valid0, in_ready0, busy0, out_data0);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid0 !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midreset_ghost got %0d valid cycles want 0", seen); end
    set_uniform(256, 64, 0);
    accept_job(0, 2'd0, {4{16'd640}}, w);
    wait_valid(0, lat);
    pop_exp(e);
    checks++;
    if (lat !== 4 || out_data0 !== e) begin
      errors++;
      $display("FAIL midreset_next got lat=%0d data=%h want lat=4 data=%h", lat, out_data0, e);
    end
  endtask

  task automatic test_lanes3();
    int w;
    int lat;
    logic [63:0] e;
    set_uniform(256, 0, -10);
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < IW; i++) w_v[n][i] = 16'(256 * (i + 1));
    accept_job(1, 2'd0, {4{16'd14070}}, w);
    wait_valid(1, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL lanes3_latency got %0d want 5", lat); end
    pop_exp(e);
    checks++;
    if (out_data3 !== e) begin errors++; $display("FAIL lanes3_data got %h want %h", out_data3, e); end
  endtask

  task automatic test_random();
    int w;
    int lat;
    logic [63:0] e;
    logic [1:0] m;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < IW; i++) a_v[i] = 16'(int'($urandom_range(2047)) - 1024);
      for (int n = 0; n < NN; n++) begin
        b_v[n] = 16'(int'($urandom_range(600)) - 300);
        for (int i = 0; i < IW; i++) w_v[n][i] = 16'(int'($urandom_range(1023)) - 512);
      end
      m = 2'($urandom);
      accept_job(0, m, model_vec(m), w);
      wait_valid(0, lat);
      pop_exp(e);
      checks++;
      if (lat !== 4 || odat(0) !== e) begin
        errors++;
        $display("FAIL random_job%0d mode=%0d got lat=%0d data=%h want lat=4 data=%h",
                 j, m, lat, odat(0), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_relu_basic();
    test_negative_modes();
    test_saturation();
    test_back_to_back();
    test_reset_midjob();
    test_lanes3();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_layer_act.md
NEURON_LAYER_ACT -- requirements
Module: neuron_layer_act

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 10, inputs per neuron.
REQ-002 SHALL have parameter NUM_NEURONS, default 4, parallel output channels.
REQ-003 SHALL have parameter LANES, default 4, multipliers per neuron per cycle; BEATS = ceil(INPUT_WIDTH/LANES).
REQ-004 SHALL have parameter DATA_WIDTH, default 16, signed fixed-point word width.
REQ-005 SHALL have parameter ACC_WIDTH, default 48, signed accumulator width.
REQ-006 SHALL have parameter FRAC_BITS, default 8, fractional bits of operands and result.
REQ-007 SHALL have parameter LEAK_SHIFT, default 3, leaky-ReLU slope 2^-LEAK_SHIFT.
REQ-008 SHALL have ports, in order: clk in 1 clock; rst_n in 1 asynchronous active-low reset; in_valid in 1; in_ready out 1; a_in in DATA_WIDTH x INPUT_WIDTH signed activations; w_in in DATA_WIDTH x NUM_NEURONS x INPUT_WIDTH signed weights; bias in DATA_WIDTH x NUM_NEURONS signed; act_mode in 2; out_data out DATA_WIDTH x NUM_NEURONS signed; out_valid out 1; out_ready in 1; busy out 1.
REQ-009 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-010 SHALL implement FSM states IDLE, MAC, FIN, HOLD.
REQ-011 SHALL drive in_ready = (state==IDLE) or (state==HOLD and out_ready).
REQ-012 SHALL accept a job on a clock edge where in_valid and in_ready, registering a_in, w_in, bias, act_mode, clearing all accumulators, entering MAC.
REQ-013 SHALL ignore a_in/w_in/bias/act_mode changes after acceptance until the next acceptance.
REQ-014 SHALL in MAC, on beat b (0..BEATS-1), add sign-extended products a[i]*w[n][i] for i = b*LANES..b*LANES+LANES-1 to accumulator n; indices >= INPUT_WIDTH contribute zero.
REQ-015 SHALL leave MAC for FIN after exactly BEATS cycles.
REQ-016 SHALL in FIN, per neuron: sum = acc + (bias sign-extended, shifted left FRAC_BITS); y = sum arithmetic-shifted right FRAC_BITS; saturate y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; apply activation; register into out_data; set out_valid; enter HOLD.
REQ-017 SHALL apply activation after saturation: act_mode 0 identity; 1 ReLU (negative -> 0); 2 leaky (negative -> y arithmetic-shift-right LEAK_SHIFT, toward -inf); 3 treated as ReLU.
REQ-018 SHALL assert out_valid exactly BEATS+1 clock edges after the acceptance edge.
REQ-019 SHALL hold out_data and out_valid stable in HOLD while out_ready is low.
REQ-020 SHALL on out_valid and out_ready with in_valid low, clear out_valid and return to IDLE.
REQ-021 SHALL on out_valid, out_ready and in_valid together, complete output and accept the new job in the same edge (back-to-back, no bubble).
REQ-022 SHALL drive busy high in MAC, FIN and HOLD; low in IDLE.
REQ-023 SHALL never overflow ACC_WIDTH for default parameters; wrap is permitted only if user-chosen ACC_WIDTH < 2*DATA_WIDTH+clog2(INPUT_WIDTH)+1.

Reset
REQ-024 SHALL on rst_n low, immediately force state IDLE, out_valid 0, out_data all 0, accumulators 0, beat counter 0; in_ready 1 and busy 0 follow.
REQ-025 SHALL discard any in-flight job on reset; no output for it after release.

Configuration
REQ-026 SHALL compile leaky mode only when macro NEURON_LEAKY_RELU_EN is defined; otherwise act_mode 2 behaves as ReLU and LEAK_SHIFT is unused.

Verification
REQ-027 SHALL cover: defaults, all a=256, all w=128, bias=0, mode 1 -> out_data all 1280, out_valid 4 edges after accept.
REQ-028 SHALL cover: all a=256, w=-128, bias=0 -> mode 0: -1280; mode 1: 0; mode 2 with NEURON_LEAKY_RELU_EN: -160, without: 0.
REQ-029 SHALL cover: all a=32767, w=32767 -> 32767 (mode 0); all a=32767, w=-32767 -> -32768 (mode 0), 0 (mode 1).
REQ-030 SHALL cover: out_ready low 10 cycles -> out_data/out_valid stable, in_ready low; then out_ready and in_valid together -> second job accepted same edge, its result 4 edges later.
REQ-031 SHALL cover: rst_n pulsed low during MAC beat 1 -> out_valid 0, in_ready 1 immediately; next job yields correct result with no residue.
REQ-032 SHALL cover: INPUT_WIDTH=10, LANES=3, a[i]=256, w[i]=256*(i+1), bias=-10 (neuron 0) -> out_data[0]=14070, out_valid 5 edges after accept.
